tdc_event_packer: RTL
=====================

TDC_EVENT_PACKER -- requirements
Module: tdc_event_packer

Interface
REQ-001 The block SHALL have parameter COARSE_W, default 8, giving the coarse-counter width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of result-FIFO entries (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start_valid, input, 1 bit: one-cycle pulse marking a filtered start hit.
REQ-006 The block SHALL have port bin_start, input, 5 bits: start-line fine bin, valid in the start_valid cycle.
REQ-007 The block SHALL have port stop_valid, input, 1 bit: one-cycle pulse marking a filtered stop hit.
REQ-008 The block SHALL have port bin_stop, input, 5 bits: stop-line fine bin, valid in the stop_valid cycle.
REQ-009 The block SHALL have port m_data, output, COARSE_W+5 bits: interval result at the FIFO head.
REQ-010 The block SHALL have port m_valid, output, 1 bit: the FIFO is non-empty and m_data is valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit: consumer accepts m_data; a pop occurs when m_valid and m_ready are both high.
REQ-012 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port drop_cnt, output, 8 bits: saturating count of results lost to a full FIFO.
REQ-014 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a start receives no stop before the coarse counter saturates.

Function
REQ-015 The block SHALL implement FSM states IDLE, ARMED, CALC and PUSH.
REQ-016 IDLE: on start_valid, the block SHALL register bin_start, set coarse to 1 and go to ARMED; stop_valid in IDLE SHALL be ignored, including when it coincides with start_valid.
REQ-017 ARMED: on stop_valid, the block SHALL register bin_stop, hold coarse and go to CALC; otherwise it SHALL increment coarse.
REQ-018 ARMED: if coarse equals 2^COARSE_W-1 and stop_valid is low, the block SHALL pulse timeout for one cycle, discard the event and go to IDLE.
REQ-019 ARMED: start_valid SHALL be ignored (no re-arm).
REQ-020 Coarse value: a stop arriving k cycles after the start cycle SHALL yield coarse = k, with 1 <= k <= 2^COARSE_W-1.
REQ-021 CALC: the block SHALL register result = coarse*32 + bin_start - bin_stop as an unsigned COARSE_W+5-bit value, then go to PUSH.
REQ-022 Result range: the result SHALL never go negative or overflow (minimum 1, maximum (2^COARSE_W-1)*32+31), so no clamping is required.
REQ-023 PUSH: the block SHALL write the result to the FIFO when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-024 PUSH: otherwise the block SHALL drop the result and increment drop_cnt, saturating at 255.
REQ-025 PUSH: the block SHALL return to IDLE unconditionally after one cycle.
REQ-026 Latency: with an empty FIFO, a stop_valid in cycle N SHALL give m_valid=1 with the result on m_data from cycle N+3.
REQ-027 Events: start/stop pulses arriving in CALC or PUSH SHALL be ignored; the minimum event spacing is start-to-start = k+3 cycles.
REQ-028 FIFO organisation: the FIFO SHALL be first-word-fall-through, with m_data driven from the head entry and pointers wrapping modulo FIFO_DEPTH.
REQ-029 FIFO output stability: while m_valid=1 and m_ready=0, m_data and m_valid SHALL hold stable.
REQ-030 Push/pop accounting: a simultaneous push and pop SHALL leave fifo_count unchanged; m_valid SHALL equal (fifo_count != 0).
REQ-031 Empty FIFO: a pop request while empty SHALL have no effect.

Reset
REQ-032 When rst_n=0 at a rising clk edge, the block SHALL enter IDLE, clear coarse, the FIFO pointers and the captured bins, and force m_valid=0, fifo_count=0, drop_cnt=0 and timeout=0.
REQ-033 m_data SHALL be 0 after reset.
REQ-034 Reset asserted mid-event (ARMED/CALC/PUSH) SHALL discard the event with no FIFO write.
REQ-035 The block SHALL ignore start_valid in the cycle in which rst_n is low.

Verification
REQ-036 The bench SHALL cover: start_valid with bin_start=10, stop_valid 4 cycles later with bin_stop=3 -> m_data=135 and m_valid=1 exactly 3 cycles after stop.
REQ-037 The bench SHALL cover: start with bin_start=0, stop next cycle with bin_stop=31 -> m_data=1 (minimum interval).
REQ-038 The bench SHALL cover: start with no stop -> timeout pulses once, 255 cycles after start (COARSE_W=8); FIFO stays empty; next start is accepted normally.
REQ-039 The bench SHALL cover: m_ready=0, 10 back-to-back events -> fifo_count=8, drop_cnt=2, and the first 8 results are read in order once m_ready=1.
REQ-040 The bench SHALL cover: FIFO full with m_ready=1 during PUSH -> the push is accepted, drop_cnt is unchanged and fifo_count stays 8.
REQ-041 The bench SHALL cover: rst_n low for 1 cycle while ARMED -> state IDLE, no result produced, and a stop pulse after reset is ignored.

Source files
------------

// File: rtl/tdc_event_packer.sv
// tdc_event_packer: turns filtered start/stop TDC hits into interval words
// (coarse*32 + bin_start - bin_stop) and queues them in a FWFT result FIFO.
//   clk, rst_n              : clock, synchronous active-low reset
//   start_valid, bin_start  : start hit pulse and its fine bin
//   stop_valid, bin_stop    : stop hit pulse and its fine bin
//   m_data, m_valid, m_ready: FIFO head with valid/ready handshake
//   fifo_count              : FIFO occupancy
//   drop_cnt                : saturating count of results lost to a full FIFO
//   timeout                 : one-cycle pulse when a start never saw a stop
module tdc_event_packer #(
  parameter int unsigned COARSE_W   = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  input  logic [4:0]                    bin_start,
  input  logic                          stop_valid,
  input  logic [4:0]                    bin_stop,
  output logic [COARSE_W+4:0]           m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_cnt,
  output logic                          timeout
);

  localparam int unsigned RES_W = COARSE_W + 5;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CALC, S_PUSH} state_t;

  state_t              r_state, w_next_state;
  logic                w_arm, w_capture_stop, w_inc, w_timeout;
  logic [COARSE_W-1:0] r_coarse;
  logic [4:0]          r_bin_start, r_bin_stop;
  logic [RES_W-1:0]    r_result;
  logic                r_timeout;

  logic [RES_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count, w_count_next;
  logic                r_valid;
  logic [7:0]          r_drop;
  logic                w_full, w_pop, w_push, w_drop;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and event control
  always_comb begin
    w_next_state   = r_state;
    w_arm          = 1'b0;
    w_capture_stop = 1'b0;
    w_inc          = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // stop hits in IDLE have no start to pair with
        if (start_valid) begin
          w_arm        = 1'b1;
          w_next_state = S_ARMED;
        end
      end
      S_ARMED: begin
        if (stop_valid) begin
          w_capture_stop = 1'b1;
          w_next_state   = S_CALC;
        end else if (r_coarse == COARSE_MAX) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_CALC:  w_next_state = S_PUSH;
      S_PUSH:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Coarse counter, bin capture and interval computation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coarse    <= '0;
      r_bin_start <= '0;
      r_bin_stop  <= '0;
      r_result    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_arm) begin
        r_bin_start <= bin_start;
        r_coarse    <= COARSE_W'(1);
      end
      if (w_inc)          r_coarse   <= r_coarse + COARSE_W'(1);
      if (w_capture_stop) r_bin_stop <= bin_stop;
      // coarse >= 1 keeps this positive; coarse max + 31 fits RES_W
      if (r_state == S_CALC)
        r_result <= {r_coarse, 5'b0} + RES_W'(r_bin_start) - RES_W'(r_bin_stop);
    end
  end

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = r_valid & m_ready;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign w_push = (r_state == S_PUSH) & (~w_full | w_pop);
  assign w_drop = (r_state == S_PUSH) & ~w_push;

  // Occupancy update
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Result FIFO storage, pointers and drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_result;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign m_data     = r_mem[r_rd_ptr];
  assign m_valid    = r_valid;
  assign fifo_count = r_count;
  assign drop_cnt   = r_drop;
  assign timeout    = r_timeout;

endmodule
